// File: rtl/pe_seq_pkg.sv
// Shared state encoding, default geometry and capture width for the PE sample sequencer.
package pe_seq_pkg;

  localparam int DEF_N  = 8;
  localparam int DEF_DW = 16;
  localparam int Y_W    = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period divider: counts 0..DIV-1 while en is high and flags the last count
// combinationally. Dropping en clears the count, so every run starts from zero.
module sample_tick_gen #(
  parameter int DIV = 30
) (
  input  logic clk30x,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk30x) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pe_sample_sequencer.sv
// Plays the sample memory PASSES times into a PE, one sample per DIV-cycle tick, capturing
// the PE output on each tick; all outputs are registered on the tick edge, no backpressure.
module pe_sample_sequencer
  import pe_seq_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DW     = DEF_DW,
  parameter int DIV    = 30,
  parameter int PASSES = 3,
  localparam int AW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk30x,
  input  logic           rst,
  input  logic           start,
  input  logic           ld_en,
  input  logic [AW-1:0]  ld_addr,
  input  logic [DW-1:0]  ld_data,
  output logic [DW-1:0]  xin,
  output logic           pe_rst,
  input  logic [DW-1:0]  yout,
  output logic [Y_W-1:0] y32,
  output logic           y_valid,
  output logic [AW-1:0]  sample_idx,
  output logic           busy,
  output logic           done
);

  localparam int PW = $clog2(PASSES + 1);

  seq_state_t state_q, state_d;

  logic [DW-1:0]  mem_q [N];
  logic [AW-1:0]  idx_q, idx_d;
  logic [PW-1:0]  pass_q, pass_d;
  logic [DW-1:0]  xin_q, xin_d;
  logic [Y_W-1:0] y32_q, y32_d;
  logic [AW-1:0]  sidx_q, sidx_d;
  logic           pe_rst_q, pe_rst_d;
  logic           yv_q, yv_d;
  logic           done_q, done_d;

  logic tick;
  logic last_tick;
  logic wr_ok;

  sample_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk30x (clk30x),
    .rst    (rst),
    .en     (state_q == ST_RUN),
    .tick   (tick)
  );

  // Once every pass has played, the next tick is the closing one.
  assign last_tick = (pass_q == PW'(PASSES));

  assign wr_ok = (state_q == ST_IDLE) && ld_en && ({1'b0, ld_addr} < (AW + 1)'(N));

  always_ff @(posedge clk30x) begin
    if (wr_ok) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk30x) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (tick && last_tick) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    pass_d   = pass_q;
    xin_d    = xin_q;
    y32_d    = y32_q;
    sidx_d   = sidx_q;
    pe_rst_d = pe_rst_q;
    yv_d     = 1'b0;
    done_d   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        idx_d  = '0;
        pass_d = '0;
      end
    end else if (tick) begin
      if (last_tick) begin
        pe_rst_d = 1'b1;
        xin_d    = '0;
        done_d   = 1'b1;
      end else begin
        y32_d    = Y_W'($signed(yout));
        yv_d     = 1'b1;
        xin_d    = mem_q[idx_q];
        sidx_d   = idx_q;
        pe_rst_d = 1'b0;
        if (idx_q == AW'(N - 1)) begin
          idx_d  = '0;
          pass_d = pass_q + 1'b1;
        end else begin
          idx_d  = idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk30x) begin
    if (rst) begin
      idx_q    <= '0;
      pass_q   <= '0;
      xin_q    <= '0;
      y32_q    <= '0;
      sidx_q   <= '0;
      pe_rst_q <= 1'b1;
      yv_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      pass_q   <= pass_d;
      xin_q    <= xin_d;
      y32_q    <= y32_d;
      sidx_q   <= sidx_d;
      pe_rst_q <= pe_rst_d;
      yv_q     <= yv_d;
      done_q   <= done_d;
    end
  end

  assign xin        = xin_q;
  assign pe_rst     = pe_rst_q;
  assign y32        = y32_q;
  assign y_valid    = yv_q;
  assign sample_idx = sidx_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = done_q;

endmodule

// File: tb/tb_pe_sample_sequencer.sv
// Scoreboard bench: drivers queue expected captures/done times, monitors pop on y_valid/done.
`timescale 1ns/1ps
module tb_pe_sample_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, ld_en, use_ovr;
  logic [2:0]  ld_addr, sample_idx;
  logic [15:0] ld_data, xin, yout, ovr_val, pe_q;
  logic [31:0] y32;
  logic        pe_rst, y_valid, busy, done;

  logic        start2, ld_en2, pe_rst2, y_valid2, busy2, done2;
  logic [2:0]  ld_addr2, sidx2;
  logic [15:0] ld_data2, xin2, yout2, pe2_q;
  logic [31:0] y32_2;

  pe_sample_sequencer dut (
    .clk30x(clk), .rst(rst), .start(start), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .xin(xin), .pe_rst(pe_rst), .yout(yout), .y32(y32),
    .y_valid(y_valid), .sample_idx(sample_idx), .busy(busy), .done(done)
  );

  pe_sample_sequencer #(.N(5), .DW(16), .DIV(4), .PASSES(1)) dut2 (
    .clk30x(clk), .rst(rst), .start(start2), .ld_en(ld_en2), .ld_addr(ld_addr2),
    .ld_data(ld_data2), .xin(xin2), .pe_rst(pe_rst2), .yout(yout2), .y32(y32_2),
    .y_valid(y_valid2), .sample_idx(sidx2), .busy(busy2), .done(done2)
  );

  // PE model: output is the previous cycle's input.
  always @(posedge clk) begin
    pe_q  <= xin;
    pe2_q <= xin2;
  end
  assign yout  = use_ovr ? ovr_val : pe_q;
  assign yout2 = pe2_q;

  typedef struct {
    logic [31:0] y;
    int          idx;
    int          t;
  } exp_t;

  exp_t        exp_q[$], exp2_q[$];
  int          done_q[$], done2_q[$];
  logic [15:0] tb_mem [8];
  int cyc = 0, t0 = 0, t0_2 = 0;
  int checks = 0, failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (y_valid) begin
      if (exp_q.size() == 0) begin
        chk("y_valid_unexpected", {31'b0, y_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("y32", y32, e.y);
        chk("sample_idx", 32'(sample_idx), 32'(e.idx));
        chk("tick_cycle", 32'(cyc - t0), 32'(e.t));
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", {31'b0, done}, 32'd0);
      end else begin
        chk("done_cycle", 32'(cyc - t0), 32'(done_q.pop_front()));
        chk("pe_rst_at_done", {31'b0, pe_rst}, 32'd1);
        chk("xin_at_done", {16'b0, xin}, 32'd0);
        chk("y_valid_at_done", {31'b0, y_valid}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (y_valid2) begin
      if (exp2_q.size() == 0) begin
        chk("n5_y_valid_unexpected", {31'b0, y_valid2}, 32'd0);
      end else begin
        e = exp2_q.pop_front();
        chk("n5_y32", y32_2, e.y);
        chk("n5_sample_idx", 32'(sidx2), 32'(e.idx));
        chk("n5_tick_cycle", 32'(cyc - t0_2), 32'(e.t));
      end
    end
    if (done2) begin
      if (done2_q.size() == 0) chk("n5_done_unexpected", {31'b0, done2}, 32'd0);
      else chk("n5_done_cycle", 32'(cyc - t0_2), 32'(done2_q.pop_front()));
    end
  end

  // Full default run: 24 captures 30 cycles apart, done at 750.
  task automatic push_full(input bit ovr);
    exp_t e;
    for (int k = 1; k <= 24; k++) begin
      if (ovr)         e.y = (k == 1) ? 32'hFFFF8000 : 32'h00007FFF;
      else if (k == 1) e.y = 32'h0;
      else             e.y = {{16{tb_mem[(k-2)%8][15]}}, tb_mem[(k-2)%8]};
      e.idx = (k - 1) % 8;
      e.t   = 30 * k;
      exp_q.push_back(e);
    end
    done_q.push_back(750);
  endtask

  task automatic issue_start();
    start = 1'b1;
    t0    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk({name, "_timeout"}, {31'b0, done}, 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!y_valid && n < budget);
    if (!y_valid) chk("y_valid_timeout", {31'b0, y_valid}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    use_ovr = 1'b0; ovr_val = '0;
    start2 = 1'b0; ld_en2 = 1'b0; ld_addr2 = '0; ld_data2 = '0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("rst_busy",       {31'b0, busy},       32'd0);
    chk("rst_pe_rst",     {31'b0, pe_rst},     32'd1);
    chk("rst_xin",        {16'b0, xin},        32'd0);
    chk("rst_y32",        y32,                 32'd0);
    chk("rst_sample_idx", {29'b0, sample_idx}, 32'd0);
    chk("rst_y_valid",    {31'b0, y_valid},    32'd0);
    chk("rst_done",       {31'b0, done},       32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_with_rst_ignored", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      ld_en = 1'b1; ld_addr = 3'(i); ld_data = 16'(i + 1); tb_mem[i] = 16'(i + 1);
      @(negedge clk);
    end
    ld_en = 1'b0;

    // Plain playback of 1..8, three passes.
    push_full(1'b0);
    issue_start();
    chk("busy_in_run", {31'b0, busy}, 32'd1);
    wait_done(800, "runA");
    @(negedge clk);
    chk("runA_idle_busy",   {31'b0, busy},   32'd0);
    chk("runA_idle_pe_rst", {31'b0, pe_rst}, 32'd1);
    chk("runA_idle_xin",    {16'b0, xin},    32'd0);
    repeat (5) @(negedge clk);

    // Sign extension of both extremes; load and start while busy are ignored.
    use_ovr = 1'b1; ovr_val = 16'h8000;
    push_full(1'b1);
    issue_start();
    wait_valid(40);
    ovr_val = 16'h7FFF;
    repeat (100) @(negedge clk);
    ld_en = 1'b1; ld_addr = 3'd3; ld_data = 16'hBEEF; start = 1'b1;
    @(negedge clk);
    ld_en = 1'b0; start = 1'b0;
    wait_done(800, "runB");
    use_ovr = 1'b0;
    repeat (5) @(negedge clk);

    // Abort with rst at cycle 100 of a run.
    for (int k = 1; k <= 3; k++) begin
      e.y   = (k == 1) ? 32'h0 : {16'h0, tb_mem[k-2]};
      e.idx = k - 1;
      e.t   = 30 * k;
      exp_q.push_back(e);
    end
    issue_start();
    while (cyc - t0 < 99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",       {31'b0, busy},       32'd0);
    chk("abort_pe_rst",     {31'b0, pe_rst},     32'd1);
    chk("abort_xin",        {16'b0, xin},        32'd0);
    chk("abort_y32",        y32,                 32'd0);
    chk("abort_sample_idx", {29'b0, sample_idx}, 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_stays_idle", {31'b0, busy}, 32'd1 - 32'd1);
    chk("abort_exp_left", 32'(exp_q.size()), 32'd0);

    // Load and start in the same IDLE cycle; mem[3] must still be 4.
    ld_en = 1'b1; ld_addr = 3'd0; ld_data = 16'h1234; tb_mem[0] = 16'h1234;
    push_full(1'b0);
    issue_start();
    ld_en = 1'b0;
    wait_valid(40);
    chk("xin_first_tick", {16'b0, xin}, 32'h0000_1234);
    wait_done(800, "runD");
    repeat (5) @(negedge clk);

    // N=5 build: out-of-range address must not disturb the memory.
    for (int i = 0; i < 5; i++) begin
      ld_en2 = 1'b1; ld_addr2 = 3'(i); ld_data2 = 16'h000A + 16'(i);
      @(negedge clk);
    end
    ld_en2 = 1'b1; ld_addr2 = 3'd6; ld_data2 = 16'hFFFF;
    @(negedge clk);
    ld_en2 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      e.y   = (k == 1) ? 32'h0 : 32'h0000_000A + 32'(k - 2);
      e.idx = k - 1;
      e.t   = 4 * k;
      exp2_q.push_back(e);
    end
    done2_q.push_back(24);
    start2 = 1'b1; t0_2 = cyc + 1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (30) @(negedge clk);
    chk("n5_idle_after_run", {31'b0, busy2}, 32'd0);

    chk("exp_left",       32'(exp_q.size()),   32'd0);
    chk("done_left",      32'(done_q.size()),  32'd0);
    chk("n5_exp_left",    32'(exp2_q.size()),  32'd0);
    chk("n5_done_left",   32'(done2_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
